rx_data_lane: RTL and testbench
===============================

Name: rx_data_lane

Overview:
- Receive data lane of the MIPI D-PHY monitor.
- Sits beside, and directly downstream of, RX_CLK_LANE, and consumes its RX_HS_CLK qualifier.
- Decodes the LP handshake on DDp/DDn (LP-11 -> LP-01 -> LP-00), waits Ths_settle, then hunts for the HS sync byte 0xB8 and deserialises the payload LSB-first into bytes for the protocol layer.
- Monitor-level model: one HS bit per clk cycle, sampled as DDp while DDp != DDn.

Parameters:
- Ths_settle, 3, clk cycles in LP-00 before sync hunting starts.
- Ths_timeout, 64, max clk cycles spent in HS_SYNC before RX_SYNC_ERR.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- DDp  input  1  data lane positive line.
- DDn  input  1  data lane negative line.
- RX_HS_CLK  input  1  from RX_CLK_LANE; high while the clock lane is in HS receive.
- RX_BYTE  output  8  last completed payload byte (registered).
- RX_VALID  output  1  one-cycle strobe; RX_BYTE is new.
- RX_ACTIVE  output  1  high while in HS_DATA.
- RX_SYNC_ERR  output  1  one-cycle pulse on sync timeout.
- RX_CLK_LOSS  output  1  one-cycle pulse when RX_HS_CLK falls during HS_DATA.

Behaviour:
- Reset (async): state = WAIT_STOP; all outputs 0; shift register, bit counter and timer cleared. Reset mid-packet drops all outputs to 0 immediately; a partial byte is lost.
- Line codes: LP11 = DDp=1,DDn=1; LP01 = 0,1; LP00 = 0,0; HS bit = DDp when DDp != DDn.
- WAIT_STOP:
  - LP11 -> STOP.
  - Otherwise stay; ignore all input.
- STOP:
  - LP01 -> HS_RQST.
  - Any other code -> stay (escape entry via LP10 is not supported).
- HS_RQST:
  - LP01 -> stay.
  - LP00 -> HS_PREP, timer=0.
  - LP11 -> STOP.
  - LP10 -> WAIT_STOP.
- HS_PREP:
  - LP11 -> STOP (priority over everything).
  - Otherwise timer increments.
  - When timer reaches Ths_settle-1 -> HS_SYNC, timer=0, shreg=0, bitcnt=0.
- HS_SYNC:
  - LP11 -> STOP, no error.
  - Timer increments every cycle.
  - When RX_HS_CLK=1 and DDp != DDn: shreg <= {DDp, shreg[7:1]} and bitcnt saturates at 8.
  - LP00 cycles and RX_HS_CLK=0 cycles shift nothing.
  - On the cycle the shift makes bitcnt>=8 and shreg==8'hB8 -> HS_DATA, bitcnt=0.
  - Sync detection takes priority over timeout.
  - When timer reaches Ths_timeout-1 without sync: RX_SYNC_ERR=1 for one cycle -> WAIT_STOP.
- HS_DATA:
  - RX_ACTIVE=1.
  - Each valid bit (RX_HS_CLK=1, DDp != DDn) shifts into shreg and increments bitcnt.
  - On the 8th bit: RX_BYTE <= assembled byte, RX_VALID=1 on the next cycle (latency 1 clk after the last bit), bitcnt=0.
  - LP00 bits are skipped.
  - LP11 -> STOP; the partial byte is discarded with no RX_VALID. A byte completing in the same cycle is impossible, because LP11 is not a bit.
  - RX_HS_CLK 1->0 -> RX_CLK_LOSS pulse -> WAIT_STOP, partial byte discarded.
- Trail bits are not stripped; trailing bytes are delivered as data.
- RX_VALID and the error pulses never assert in the same cycle.
- RX_BYTE holds its value between strobes.
- LP11 in any state other than WAIT_STOP/STOP returns to STOP within one cycle. RX_ACTIVE falls on the cycle after LP11 is sampled.
- Counters:
  - timer width = clog2(max(Ths_settle, Ths_timeout)) + 1.
  - bitcnt is 4 bits.

Test Plan:
- Reset, LP11 for 2 cycles, LP01, LP00 for 3 cycles, RX_HS_CLK=1, then bits 0,0,0,1,1,1,0,1 followed by bytes 0x5A, 0xC3 LSB-first, then LP11 -> RX_VALID pulses twice with RX_BYTE=0x5A then 0xC3; each pulse 1 clk after the byte's 8th bit; RX_ACTIVE high from sync until 1 cycle after LP11.
- Same entry with 5 random bits before 0xB8 -> no false sync; first RX_BYTE matches the first payload byte.
- HS entry with no 0xB8 for 64 cycles -> RX_SYNC_ERR single pulse at cycle 64 of HS_SYNC; no RX_VALID; lane ignores input until LP11.
- Payload 0xFF plus 4 bits, then LP11 -> exactly one RX_VALID (0xFF); partial byte dropped; next LP01/LP00 sequence is accepted.
- Drop RX_HS_CLK to 0 mid-byte in HS_DATA -> RX_CLK_LOSS one pulse, RX_ACTIVE=0, no RX_VALID; recovery only after LP11.
- Assert rst while RX_ACTIVE=1 -> all outputs 0 asynchronously; after release, LP01 is ignored until LP11 has been seen.

Source files
------------

// File: rtl/rx_data_lane.sv
// D-PHY monitor receive data lane: decodes the LP-11/01/00 HS entry, hunts for
// the 0xB8 sync byte and deserialises the LSB-first HS payload into bytes.
module rx_data_lane #(
    parameter int THS_SETTLE  = 3,   // must be >= 2
    parameter int THS_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       DDp,
    input  logic       DDn,
    input  logic       RX_HS_CLK,
    output logic [7:0] RX_BYTE,
    output logic       RX_VALID,
    output logic       RX_ACTIVE,
    output logic       RX_SYNC_ERR,
    output logic       RX_CLK_LOSS
);

    localparam int TMR_MAX = (THS_SETTLE > THS_TIMEOUT) ? THS_SETTLE : THS_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [7:0]       SYNC_BYTE    = 8'hB8;
    // The HS_RQST cycle that sees LP-00 is the first settle cycle.
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(THS_SETTLE - 2);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(THS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_STOP, STOP, HS_RQST, HS_PREP, HS_SYNC, HS_DATA
    } state_t;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [7:0]       shreg_q;
    logic [3:0]       bitcnt_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             active_q;
    logic             sync_err_q;
    logic             clk_loss_q;

    logic       lp11, lp01, lp00, lp10, hs_bit, sync_hit;
    logic [7:0] shreg_d;

    assign lp11     = DDp & DDn;
    assign lp01     = ~DDp & DDn;
    assign lp00     = ~DDp & ~DDn;
    assign lp10     = DDp & ~DDn;
    assign hs_bit   = RX_HS_CLK & (DDp ^ DDn);
    assign shreg_d  = {DDp, shreg_q[7:1]};
    assign sync_hit = hs_bit && (bitcnt_q >= 4'd7) && (shreg_d == SYNC_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_STOP;
            timer_q    <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            sync_err_q <= 1'b0;
            clk_loss_q <= 1'b0;
        end else begin
            // NOTE: strobes default low here; a later non-blocking assignment in
            // the same block wins, so each pulse lasts exactly one cycle.
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            sync_err_q <= 1'b0;
            clk_loss_q <= 1'b0;

            case (state_q)
                WAIT_STOP: if (lp11) state_q <= STOP;

                STOP: if (lp01) state_q <= HS_RQST;

                HS_RQST: begin
                    if (lp00) begin
                        state_q <= HS_PREP;
                        timer_q <= '0;
                    end else if (lp11) begin
                        state_q <= STOP;
                    end else if (lp10) begin
                        state_q <= WAIT_STOP;
                    end
                end

                HS_PREP: begin
                    if (lp11) begin
                        state_q <= STOP;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_q  <= HS_SYNC;
                        timer_q  <= '0;
                        shreg_q  <= '0;
                        bitcnt_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                HS_SYNC: begin
                    if (lp11) begin
                        state_q <= STOP;
                    end else if (sync_hit) begin
                        state_q  <= HS_DATA;
                        shreg_q  <= shreg_d;
                        bitcnt_q <= '0;
                        active_q <= 1'b1;
                    end else begin
                        if (hs_bit) begin
                            shreg_q <= shreg_d;
                            if (bitcnt_q < 4'd8) bitcnt_q <= bitcnt_q + 4'd1;
                        end
                        if (timer_q == TIMEOUT_LAST) begin
                            state_q    <= WAIT_STOP;
                            sync_err_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end

                HS_DATA: begin
                    if (lp11) begin
                        state_q <= STOP;
                    end else if (!RX_HS_CLK) begin
                        state_q    <= WAIT_STOP;
                        clk_loss_q <= 1'b1;
                    end else begin
                        active_q <= 1'b1;
                        if (hs_bit) begin
                            shreg_q <= shreg_d;
                            if (bitcnt_q == 4'd7) begin
                                byte_q   <= shreg_d;
                                valid_q  <= 1'b1;
                                bitcnt_q <= '0;
                            end else begin
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end
                        end
                    end
                end

                default: state_q <= WAIT_STOP;
            endcase
        end
    end

    assign RX_BYTE     = byte_q;
    assign RX_VALID    = valid_q;
    assign RX_ACTIVE   = active_q;
    assign RX_SYNC_ERR = sync_err_q;
    assign RX_CLK_LOSS = clk_loss_q;

endmodule

// File: tb/tb_rx_data_lane.sv
// Bench for rx_data_lane: directed scenarios with random bytes/bits; expected
// outputs come from event marks placed while building each line sequence.
module tb_rx_data_lane;

    logic       clk = 1'b0;
    logic       rst;
    logic       DDp, DDn, RX_HS_CLK;
    logic [7:0] RX_BYTE;
    logic       RX_VALID, RX_ACTIVE, RX_SYNC_ERR, RX_CLK_LOSS;

    always #5 clk = ~clk;

    rx_data_lane dut (
        .clk        (clk),
        .rst        (rst),
        .DDp        (DDp),
        .DDn        (DDn),
        .RX_HS_CLK  (RX_HS_CLK),
        .RX_BYTE    (RX_BYTE),
        .RX_VALID   (RX_VALID),
        .RX_ACTIVE  (RX_ACTIVE),
        .RX_SYNC_ERR(RX_SYNC_ERR),
        .RX_CLK_LOSS(RX_CLK_LOSS)
    );

    // One line state per clk, plus the outputs expected right after it is sampled.
    typedef struct {
        logic       dp, dn, hc;
        logic       ev_valid;
        logic [7:0] ev_byte;
        logic       ev_active, ev_err, ev_loss;
    } step_t;

    step_t      steps[$];
    logic       hunt_bits[$];
    int         hunt_step[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_byte;

    task automatic check1(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @step %0d: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @step %0d: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check8({tag, "_byte"}, -1, RX_BYTE, 8'h00);
        check1({tag, "_valid"}, -1, RX_VALID, 1'b0);
        check1({tag, "_active"}, -1, RX_ACTIVE, 1'b0);
        check1({tag, "_err"}, -1, RX_SYNC_ERR, 1'b0);
        check1({tag, "_loss"}, -1, RX_CLK_LOSS, 1'b0);
    endtask

    task automatic push(input logic dp, input logic dn, input logic hc);
        step_t s;
        s.dp = dp; s.dn = dn; s.hc = hc;
        s.ev_valid = 1'b0; s.ev_byte = 8'h00;
        s.ev_active = 1'b0; s.ev_err = 1'b0; s.ev_loss = 1'b0;
        steps.push_back(s);
    endtask

    task automatic push_bit(input logic b, input logic hc);
        push(b, ~b, hc);
    endtask

    task automatic push_entry();
        push(1'b1, 1'b1, 1'b1);
        push(1'b1, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b, output int last);
        for (int i = 0; i < 8; i++) push_bit(b[i], 1'b1);
        last = steps.size() - 1;
    endtask

    task automatic mark_active(input int first, input int stop);
        step_t s;
        for (int i = first; i < stop; i++) begin
            s = steps[i]; s.ev_active = 1'b1; steps[i] = s;
        end
    endtask

    task automatic mark_valid(input int idx, input logic [7:0] b);
        step_t s;
        s = steps[idx]; s.ev_valid = 1'b1; s.ev_byte = b; steps[idx] = s;
    endtask

    task automatic mark_err(input int idx);
        step_t s;
        s = steps[idx]; s.ev_err = 1'b1; steps[idx] = s;
    endtask

    task automatic mark_loss(input int idx);
        step_t s;
        s = steps[idx]; s.ev_loss = 1'b1; steps[idx] = s;
    endtask

    // Reference sync search: position of the first received bit that completes
    // an LSB-first 0xB8 window, or -1.
    function automatic int find_sync();
        logic [7:0] w = 8'h00;
        for (int i = 0; i < hunt_bits.size(); i++) begin
            w = {hunt_bits[i], w[7:1]};
            if (i >= 7 && w == 8'hB8) return i;
        end
        return -1;
    endfunction

    task automatic hunt_push(input logic b);
        hunt_bits.push_back(b);
        push_bit(b, 1'b1);
        hunt_step.push_back(steps.size() - 1);
    endtask

    task automatic run_steps();
        for (int k = 0; k < steps.size(); k++) begin
            DDp       = steps[k].dp;
            DDn       = steps[k].dn;
            RX_HS_CLK = steps[k].hc;
            @(posedge clk);
            #1;
            if (steps[k].ev_valid) model_byte = steps[k].ev_byte;
            check1("valid", k, RX_VALID, steps[k].ev_valid);
            check8("byte", k, RX_BYTE, model_byte);
            check1("active", k, RX_ACTIVE, steps[k].ev_active);
            check1("sync_err", k, RX_SYNC_ERR, steps[k].ev_err);
            check1("clk_loss", k, RX_CLK_LOSS, steps[k].ev_loss);
        end
        steps.delete();
    endtask

    // A good packet from STOP/WAIT_STOP: entry, sync, one byte, LP-11.
    task automatic push_good_packet();
        int sync_idx, last;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        push_entry();
        push_byte(8'hB8, sync_idx);
        push_byte(b, last);
        mark_valid(last, b);
        push(1'b1, 1'b1, 1'b1);
        mark_active(sync_idx, steps.size() - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sync_idx, last, last2, err_idx, loss_idx, found;
        logic [7:0] b1, b2;
        logic pre[5];

        rst = 1'b1; DDp = 1'b0; DDn = 1'b0; RX_HS_CLK = 1'b0;
        model_byte = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic packet: sync, 0x5A, 0xC3, LP-11.
        push_entry();
        push_byte(8'hB8, sync_idx);
        push_byte(8'h5A, last);
        mark_valid(last, 8'h5A);
        push_byte(8'hC3, last);
        mark_valid(last, 8'hC3);
        push(1'b1, 1'b1, 1'b1);
        mark_active(sync_idx, steps.size() - 1);
        push(1'b1, 1'b1, 1'b1);
        run_steps();

        // Random prefix before sync, with an LP-00 and a clockless bit inside.
        do begin
            hunt_bits.delete();
            for (int i = 0; i < 5; i++) begin
                pre[i] = 1'($urandom_range(0, 1));
                hunt_bits.push_back(pre[i]);
            end
            for (int i = 0; i < 8; i++) hunt_bits.push_back(1'((8'hB8 >> i) & 8'h01));
        end while (find_sync() != 12);
        hunt_bits.delete();
        hunt_step.delete();
        push_entry();
        hunt_push(pre[0]);
        hunt_push(pre[1]);
        push(1'b0, 1'b0, 1'b1);
        push_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 2; i < 5; i++) hunt_push(pre[i]);
        for (int i = 0; i < 8; i++) hunt_push(1'((8'hB8 >> i) & 8'h01));
        found = find_sync();
        sync_idx = hunt_step[found];
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) push_bit(b1[i], 1'b1);
        push(1'b0, 1'b0, 1'b1);
        for (int i = 4; i < 8; i++) push_bit(b1[i], 1'b1);
        mark_valid(steps.size() - 1, b1);
        push_byte(b2, last2);
        mark_valid(last2, b2);
        push(1'b1, 1'b1, 1'b1);
        mark_active(sync_idx, steps.size() - 1);
        run_steps();

        // No sync for 64 HS_SYNC cycles -> single error pulse, then deaf until LP-11.
        do begin
            hunt_bits.delete();
            for (int i = 0; i < 64; i++) hunt_bits.push_back(1'($urandom_range(0, 1)));
        end while (find_sync() != -1);
        push_entry();
        for (int i = 0; i < 64; i++) push_bit(hunt_bits[i], 1'b1);
        err_idx = steps.size() - 1;
        mark_err(err_idx);
        for (int i = 0; i < 4; i++) push_bit(1'($urandom_range(0, 1)), 1'b1);
        push(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1);
        push_byte(8'hB8, last);
        push_byte(8'($urandom_range(0, 255)), last);
        push_good_packet();
        run_steps();

        // 0xFF then 4 bits, LP-11: partial byte dropped; immediate re-entry works.
        push_entry();
        push_byte(8'hB8, sync_idx);
        push_byte(8'hFF, last);
        mark_valid(last, 8'hFF);
        for (int i = 0; i < 4; i++) push_bit(1'($urandom_range(0, 1)), 1'b1);
        push(1'b1, 1'b1, 1'b1);
        mark_active(sync_idx, steps.size() - 1);
        push(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1);
        push_byte(8'hB8, sync_idx);
        b1 = 8'($urandom_range(0, 255));
        push_byte(b1, last);
        mark_valid(last, b1);
        push(1'b1, 1'b1, 1'b1);
        mark_active(sync_idx, steps.size() - 1);
        run_steps();

        // Clock lane drops mid-byte: loss pulse, no byte, recovery needs LP-11.
        push_entry();
        push_byte(8'hB8, sync_idx);
        for (int i = 0; i < 3; i++) push_bit(1'($urandom_range(0, 1)), 1'b1);
        push_bit(1'b1, 1'b0);
        loss_idx = steps.size() - 1;
        mark_loss(loss_idx);
        mark_active(sync_idx, loss_idx);
        push(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1);
        push_byte(8'hB8, last);
        push_byte(8'($urandom_range(0, 255)), last);
        push_good_packet();
        run_steps();

        // Reset while active: outputs clear at once; LP-01 ignored until LP-11.
        push_entry();
        push_byte(8'hB8, sync_idx);
        b1 = 8'($urandom_range(0, 255));
        push_byte(b1, last);
        mark_valid(last, b1);
        for (int i = 0; i < 3; i++) push_bit(1'($urandom_range(0, 1)), 1'b1);
        mark_active(sync_idx, steps.size());
        run_steps();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        #1;
        rst = 1'b0;
        model_byte = 8'h00;
        push(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1);
        push_byte(8'hB8, last);
        push_byte(8'($urandom_range(0, 255)), last);
        push_good_packet();
        run_steps();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
